// File: rtl/cc_game_pkg.sv
// Shared types for the light-column match sequencer: FSM states and winner codes.
package cc_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        PLAY,
        OVER,
        MATCH_END
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/cc_game_tick_gen.sv
// Free-running step-tick generator: one-cycle pulse whenever the TICK_W-bit counter reads 0.
module cc_tick_gen #(
    parameter int TICK_W = 7
) (
    input  logic clk,
    input  logic reset,
    output logic step_tick
);

    logic [TICK_W-1:0] cnt;

    // step_tick is registered from the wrap compare, so it is high exactly while cnt
    // reads 0; the first pulse lands one full period after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            step_tick <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            step_tick <= (cnt == {TICK_W{1'b1}});
        end
    end

endmodule

// File: rtl/cc_game_ctrl.sv
// Match sequencer for the two-player light-column game.
// Optional round timeout: define CC_ROUND_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | lights held at default, waiting for a start edge
//   COUNTDOWN | countdown ticking down before play, lights at default
//   PLAY      | lights running, tops sampled on each step tick
//   OVER      | round decided, board frozen for HOLD_TICKS ticks
//   MATCH_END | a player reached WIN_SCORE, board frozen until start
module cc_game_ctrl
    import cc_game_pkg::*;
#(
    parameter int TICK_W      = 7,
    parameter int CD_TICKS    = 3,
    parameter int HOLD_TICKS  = 4,
    parameter int ROUND_TICKS = 64,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_top,
    input  logic               p2_top,
    output logic               step_tick,
    output logic               ongoing,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         countdown
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [1:0]         CD_VAL    = 2'(CD_TICKS);
    localparam logic [HOLD_W-1:0]  HOLD_VAL  = HOLD_W'(HOLD_TICKS);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0]  p1_d, p2_d;
    logic [1:0]          winner_d, countdown_d;
    logic                start_q, start_edge;

`ifdef CC_ROUND_TIMEOUT_EN
    localparam int RND_W = $clog2(ROUND_TICKS + 1);
    localparam logic [RND_W-1:0] RND_VAL = RND_W'(ROUND_TICKS);
    logic [RND_W-1:0] rnd_q, rnd_d;
`else
    // Round length only matters when the timeout is built in.
    logic unused_round_ticks;
    assign unused_round_ticks = |ROUND_TICKS;
`endif

    cc_tick_gen #(.TICK_W(TICK_W)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .step_tick (step_tick)
    );

    assign start_edge = start & ~start_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        p1_d        = p1_score;
        p2_d        = p2_score;
        winner_d    = winner;
        countdown_d = countdown;
`ifdef CC_ROUND_TIMEOUT_EN
        rnd_d       = rnd_q;
`endif
        case (state_q)
            IDLE, MATCH_END: begin
                if (start_edge) begin
                    p1_d        = '0;
                    p2_d        = '0;
                    winner_d    = WIN_NONE;
                    countdown_d = CD_VAL;
                    state_d     = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (step_tick) begin
                    countdown_d = countdown - 2'd1;
                    if (countdown == 2'd1) begin
                        winner_d = WIN_NONE;
                        state_d  = PLAY;
`ifdef CC_ROUND_TIMEOUT_EN
                        rnd_d    = '0;
`endif
                    end
                end
            end
            PLAY: begin
                if (step_tick) begin
                    if (p1_top || p2_top) begin
                        if (p1_top && p2_top) begin
                            winner_d = WIN_TIE;
                        end else if (p1_top) begin
                            winner_d = WIN_P1;
                            if (p1_score != SCORE_MAX) p1_d = p1_score + 1'b1;
                        end else begin
                            winner_d = WIN_P2;
                            if (p2_score != SCORE_MAX) p2_d = p2_score + 1'b1;
                        end
                        hold_d  = HOLD_VAL;
                        state_d = OVER;
                    end
`ifdef CC_ROUND_TIMEOUT_EN
                    else begin
                        rnd_d = rnd_q + 1'b1;
                        if (rnd_d == RND_VAL) begin
                            winner_d = WIN_NONE;
                            hold_d   = HOLD_VAL;
                            state_d  = OVER;
                        end
                    end
`endif
                end
            end
            OVER: begin
                if (step_tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        if (p1_score == WIN_VAL || p2_score == WIN_VAL) begin
                            state_d = MATCH_END;
                        end else begin
                            countdown_d = CD_VAL;
                            state_d     = COUNTDOWN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ongoing/game_over are decoded from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= WIN_NONE;
            countdown <= '0;
            start_q   <= 1'b0;
            ongoing   <= 1'b0;
            game_over <= 1'b0;
`ifdef CC_ROUND_TIMEOUT_EN
            rnd_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            p1_score  <= p1_d;
            p2_score  <= p2_d;
            winner    <= winner_d;
            countdown <= countdown_d;
            start_q   <= start;
            ongoing   <= (state_d == PLAY) || (state_d == OVER) || (state_d == MATCH_END);
            game_over <= (state_d == OVER) || (state_d == MATCH_END);
`ifdef CC_ROUND_TIMEOUT_EN
            rnd_q     <= rnd_d;
`endif
        end
    end

endmodule

// File: tb/tb_cc_game_ctrl.sv
// Self-checking bench for cc_game_ctrl: directed test-plan steps then random play, against a round-level model.
module tb_cc_game_ctrl;

    localparam int TW   = 2;
    localparam int CD   = 3;
    localparam int HOLD = 2;
    localparam int RT   = 4;
    localparam int SW   = 3;
    localparam int WS   = 2;
    localparam int PER  = 1 << TW;
    localparam int SMAX = (1 << SW) - 1;

    localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_OVER = 3, M_END = 4;

    logic          clk = 1'b0;
    logic          reset, start, p1_top, p2_top;
    logic          step_tick, ongoing, game_over;
    logic [1:0]    winner, countdown;
    logic [SW-1:0] p1_score, p2_score;

    int npass = 0;
    int nchk  = 0;

    int m_mode, m_cd, m_hold, m_s1, m_s2, m_win, m_rnd, m_k;
    int m_tick, m_on, m_go;
    bit m_sprev;

    cc_game_ctrl #(
        .TICK_W(TW), .CD_TICKS(CD), .HOLD_TICKS(HOLD), .ROUND_TICKS(RT),
        .SCORE_W(SW), .WIN_SCORE(WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p1_top    (p1_top),
        .p2_top    (p2_top),
        .step_tick (step_tick),
        .ongoing   (ongoing),
        .game_over (game_over),
        .winner    (winner),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .countdown (countdown)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    // Reference: what the outputs should read after the next clock edge, given this cycle's inputs.
    task automatic model_step(input bit r, input bit s, input bit a, input bit b);
        bit sedge;
        if (r) begin
            m_mode = M_IDLE; m_cd = 0; m_hold = 0; m_s1 = 0; m_s2 = 0;
            m_win = 0; m_rnd = 0; m_k = 0; m_tick = 0; m_sprev = 0;
        end else begin
            sedge   = s && !m_sprev;
            m_sprev = s;
            if (m_mode == M_IDLE || m_mode == M_END) begin
                if (sedge) begin
                    m_s1 = 0; m_s2 = 0; m_win = 0; m_cd = CD; m_mode = M_CD;
                end
            end else if (m_tick == 1) begin
                if (m_mode == M_CD) begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) begin
                        m_mode = M_PLAY; m_win = 0; m_rnd = 0;
                    end
                end else if (m_mode == M_PLAY) begin
                    if (a || b) begin
                        m_win  = (a ? 1 : 0) + (b ? 2 : 0);
                        if (a && !b) m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
                        if (b && !a) m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX;
                        m_hold = HOLD; m_mode = M_OVER;
                    end else begin
`ifdef CC_ROUND_TIMEOUT_EN
                        m_rnd = m_rnd + 1;
                        if (m_rnd == RT) begin
                            m_win = 0; m_hold = HOLD; m_mode = M_OVER;
                        end
`endif
                    end
                end else if (m_mode == M_OVER) begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) begin
                        if (m_s1 == WS || m_s2 == WS) m_mode = M_END;
                        else begin m_cd = CD; m_mode = M_CD; end
                    end
                end
            end
            m_k    = m_k + 1;
            m_tick = (m_k % PER == 0) ? 1 : 0;
        end
        m_on = (m_mode == M_PLAY || m_mode == M_OVER || m_mode == M_END) ? 1 : 0;
        m_go = (m_mode == M_OVER || m_mode == M_END) ? 1 : 0;
    endtask

    task automatic check_all();
        check("step_tick", int'(step_tick), m_tick);
        check("ongoing",   int'(ongoing),   m_on);
        check("game_over", int'(game_over), m_go);
        check("winner",    int'(winner),    m_win);
        check("p1_score",  int'(p1_score),  m_s1);
        check("p2_score",  int'(p2_score),  m_s2);
        check("countdown", int'(countdown), m_cd);
    endtask

    // Called at a negedge: check current outputs, drive inputs, advance model, move to next negedge.
    task automatic cyc(input bit r, input bit s, input bit a, input bit b);
        check_all();
        reset = r; start = s; p1_top = a; p2_top = b;
        model_step(r, s, a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_mode(input int md, input int budget, input string tag);
        int n = 0;
        while (m_mode != md && n < budget) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        nchk++;
        assert (m_mode == md) npass++;
        else $error("FAIL %s wait observed_mode=%0d expected_mode=%0d", tag, m_mode, md);
    endtask

    task automatic top_tick(input bit a, input bit b);
        for (int i = 0; i < PER; i++) cyc(0, 0, a, b);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; p1_top = 1'b0; p2_top = 1'b0;
        model_step(1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_ongoing", int'(ongoing), 0);
        check("rst_winner",  int'(winner), 0);

        // first round: countdown 3,2,1 then p1 wins
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("cd_loaded", int'(countdown), 3);
        wait_mode(M_PLAY, 20 * PER, "to_play1");
        check("play_ongoing", int'(ongoing), 1);
        top_tick(1, 0);
        check("p1_win_winner", int'(winner), 1);
        check("p1_win_score",  int'(p1_score), 1);
        check("p1_win_frozen", int'(game_over), 1);
        wait_mode(M_CD, 4 * PER, "to_cd");
        cyc(0, 0, 0, 0);
        check("hold_end_ongoing", int'(ongoing), 0);
        check("hold_end_cd",      int'(countdown), 3);

        // tie round, then p2 takes the match
        wait_mode(M_PLAY, 20 * PER, "to_play2");
        top_tick(1, 1);
        check("tie_winner", int'(winner), 3);
        check("tie_p1",     int'(p1_score), 1);
        check("tie_p2",     int'(p2_score), 0);
        wait_mode(M_PLAY, 20 * PER, "to_play3");
        top_tick(0, 1);
        wait_mode(M_PLAY, 20 * PER, "to_play4");
        top_tick(0, 1);
        check("p2_two", int'(p2_score), 2);
        wait_mode(M_END, 10 * PER, "to_end");
        for (int i = 0; i < 3 * PER; i++) cyc(0, 0, 0, 0);
        check("end_frozen", int'(game_over), 1);
        check("end_winner", int'(winner), 2);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("restart_p2", int'(p2_score), 0);
        check("restart_cd", int'(countdown), 3);

        // start ignored in PLAY; then optional timeout window with no tops
        wait_mode(M_PLAY, 20 * PER, "to_play5");
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < (RT + 1) * PER; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 20 * PER && m_mode != M_OVER; i++) begin
            if (m_mode == M_PLAY) cyc(0, 0, 1, 0);
            else cyc(0, 0, 0, 0);
        end
        wait_mode(M_OVER, 1, "to_over");
        cyc(1, 0, 0, 0);
        check("mid_rst_ongoing", int'(ongoing), 0);
        check("mid_rst_over",    int'(game_over), 0);
        check("mid_rst_p1",      int'(p1_score), 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        check_all();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
